pwm_multi_gen: RTL and testbench

Multi-channel, parametrised PWM generator; successor to the single-channel 8-bit duty/step PWM block. Every channel shares one period counter and has its own duty setting, adjusted by active-low inc/dec pushbuttons in STEP increments with saturation. Duty changes are double-buffered and take effect only at a period boundary, so each PWM output is glitch-free. A mode input selects edge-aligned or center-aligned PWM. The block drives LED/motor outputs directly, and its duty readback feeds the display logic.

---
 rtl/pwm_pkg.sv | 31 +++
 rtl/pwm_btn_sync.sv | 34 +++
 rtl/pwm_multi_gen.sv | 115 +++++++++++
 tb/tb_pwm_multi_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
// The saturating helpers work on 32-bit values, so WIDTH+1-bit sums never wrap for any legal WIDTH.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  localparam int MAX_WIDTH = 30;

  function automatic logic [31:0] sat_add(input logic [31:0] val, input logic [31:0] step,
                                          input logic [31:0] lim);
    logic [31:0] sum;
    sum = val + step;
    return (sum > lim) ? lim : sum;
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] val, input logic [31:0] step);
    return (step > val) ? 32'd0 : (val - step);
  endfunction

  function automatic logic period_ok(input int width, input int period);
    return (width >= 1) && (width <= MAX_WIDTH) && (period >= 2) && (period <= (1 << width) - 1);
  endfunction

  function automatic logic step_ok(input int period, input int step);
    return (step >= 1) && (step <= period);
  endfunction

endpackage

// File: rtl/pwm_btn_sync.sv
// Active-low button synchronizer with a falling-edge detector.
// Presses become one-clock events, and all flops reset to the idle (high) level.
module pwm_btn_sync (
  input  logic clkin,
  input  logic reset,
  input  logic btn_n,
  output logic evt
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = btn_n;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign evt = prev_q & ~sync_q;

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: a shared edge/center-aligned period counter and per-channel
// double-buffered duty registers, adjusted by pushbuttons.
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PERIOD   = 50,
  parameter int STEP     = 5
) (
  input  logic                      clkin,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [CHANNELS-1:0]       dec,
  input  logic                      center,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [CHANNELS*WIDTH-1:0] d,
  output logic                      period_start
);

  if (!period_ok(WIDTH, PERIOD)) begin : g_bad_period
    $error("pwm_multi_gen: PERIOD must lie in 2..2**WIDTH-1");
  end
  if (!step_ok(PERIOD, STEP)) begin : g_bad_step
    $error("pwm_multi_gen: STEP must lie in 1..PERIOD");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("pwm_multi_gen: CHANNELS must lie in 1..8");
  end

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH-1:0] CNT_TURN = WIDTH'(PERIOD - 2);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             up_q, up_d;
  pwm_mode_e        mode_q, mode_d;
  logic             period_start_q, period_start_d;
  logic             boundary;

  always_comb begin
    boundary       = (cnt_q == '0) && up_q;
    cnt_d          = cnt_q + WIDTH'(1);
    up_d           = up_q;
    mode_d         = boundary ? pwm_mode_e'(center) : mode_q;
    period_start_d = boundary;
    if (mode_q == PWM_EDGE) begin
      if (cnt_q == CNT_LAST) cnt_d = '0;
    end else if (up_q) begin
      // With PERIOD==2 there is no down leg, so the counter stays in the up phase.
      if (cnt_q == CNT_LAST) begin
        cnt_d = CNT_TURN;
        up_d  = (CNT_TURN == '0);
      end
    end else begin
      cnt_d = cnt_q - WIDTH'(1);
      if (cnt_q == WIDTH'(1)) up_d = 1'b1;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      cnt_q          <= '0;
      up_q           <= 1'b1;
      mode_q         <= PWM_EDGE;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      up_q           <= up_d;
      mode_q         <= mode_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             inc_evt, dec_evt;
    logic [WIDTH-1:0] req_q, req_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic             pwm_q, pwm_d;

    pwm_btn_sync u_inc_sync (.clkin(clkin), .reset(reset), .btn_n(inc[i]), .evt(inc_evt));
    pwm_btn_sync u_dec_sync (.clkin(clkin), .reset(reset), .btn_n(dec[i]), .evt(dec_evt));

    always_comb begin
      req_d = req_q;
      if (inc_evt && !dec_evt) begin
        req_d = WIDTH'(sat_add(32'(req_q), 32'(STEP), 32'(PERIOD)));
      end else if (dec_evt && !inc_evt) begin
        req_d = WIDTH'(sat_sub(32'(req_q), 32'(STEP)));
      end
      act_d = boundary ? req_q : act_q;
      // The first sample of a period already uses the new duty. The down leg compares
      // with <= so a center-aligned period is high for exactly 2*duty clocks.
      if (up_q) pwm_d = (cnt_q < act_d);
      else      pwm_d = (cnt_q <= act_d);
    end

    always_ff @(posedge clkin) begin
      if (reset) begin
        req_q <= '0;
        act_q <= '0;
        pwm_q <= 1'b0;
      end else begin
        req_q <= req_d;
        act_q <= act_d;
        pwm_q <= pwm_d;
      end
    end

    assign d[i*WIDTH +: WIDTH] = req_q;
    assign pwm_out[i]          = pwm_q;
  end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed bench for pwm_multi_gen: button presses, saturation, double buffering,
// center-aligned mode and mid-period reset, all sampled on the falling clock edge.
module tb_pwm_multi_gen;

  localparam int CH  = 4;
  localparam int W   = 8;
  localparam int PER = 50;
  localparam int STP = 5;

  logic              clkin = 1'b0;
  logic              reset;
  logic              center;
  logic [CH-1:0]     inc;
  logic [CH-1:0]     dec;
  logic [CH-1:0]     pwm_out;
  logic [CH*W-1:0]   d;
  logic              period_start;

  int                tests = 0;
  int                failed = 0;
  int                hi_cnt [CH];
  int                ps_cnt;
  int                errs;
  int                pulses;
  logic [127:0]      pat;
  logic [127:0]      exp_pat;

  always #5 clkin = ~clkin;

  pwm_multi_gen #(.CHANNELS(CH), .WIDTH(W), .PERIOD(PER), .STEP(STP)) dut (
    .clkin        (clkin),
    .reset        (reset),
    .inc          (inc),
    .dec          (dec),
    .center       (center),
    .pwm_out      (pwm_out),
    .d            (d),
    .period_start (period_start)
  );

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic step();
    @(negedge clkin);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int ch, input logic do_inc, input logic do_dec, input int hold);
    if (do_inc) inc[ch] = 1'b0;
    if (do_dec) dec[ch] = 1'b0;
    repeat (hold) step();
    inc = '1;
    dec = '1;
    repeat (4) step();
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    while (period_start !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("wait_period_start", 128'(period_start), 128'(1));
  endtask

  // Samples n clocks starting at the current sample; optional mid-window press / mode switch.
  task automatic measure(input int n, input int press_ch, input int press_k, input int ctr_k,
                         input int pat_ch);
    ps_cnt = 0;
    pat    = '0;
    for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
    for (int k = 0; k < n; k++) begin
      if (press_k >= 0 && k == press_k) inc[press_ch] = 1'b0;
      if (press_k >= 0 && k == press_k + 3) inc = '1;
      if (k == ctr_k) center = 1'b1;
      for (int c = 0; c < CH; c++) if (pwm_out[c] === 1'b1) hi_cnt[c]++;
      if (period_start === 1'b1) ps_cnt++;
      pat[k] = pwm_out[pat_ch];
      step();
    end
  endtask

  initial begin
    reset  = 1'b1;
    center = 1'b0;
    inc    = '1;
    dec    = '1;
    repeat (3) step();
    check("rst_pwm_out", 128'(pwm_out), 128'(0));
    check("rst_d", 128'(d), 128'(0));
    check("rst_period_start", 128'(period_start), 128'(0));

    // Release reset: period_start pulses on the first edge, then every 50 clocks.
    reset = 1'b0;
    step();
    check("ps_after_release", 128'(period_start), 128'(1));
    errs   = 0;
    pulses = 0;
    for (int k = 1; k < 200; k++) begin
      step();
      if (period_start !== ((k % PER) == 0)) errs++;
      if (period_start === 1'b1) pulses++;
      if (pwm_out !== '0 || d !== '0) errs++;
    end
    check("idle_errors", 128'(errs), 128'(0));
    check("idle_pulses", 128'(pulses), 128'(3));

    // Three inc presses on channel 1.
    press(1, 1'b1, 1'b0, 3);
    check("ch1_d_5", 128'(d[15:8]), 128'(5));
    press(1, 1'b1, 1'b0, 3);
    check("ch1_d_10", 128'(d[15:8]), 128'(10));
    press(1, 1'b1, 1'b0, 3);
    check("ch1_d_15", 128'(d[15:8]), 128'(15));
    wait_ps();
    measure(50, -1, -1, -1, 1);
    check("ch1_high_15", 128'(hi_cnt[1]), 128'(15));
    check("ch0_low", 128'(hi_cnt[0]), 128'(0));
    check("ch2_low", 128'(hi_cnt[2]), 128'(0));
    exp_pat = '0;
    for (int k = 0; k < 15; k++) exp_pat[k] = 1'b1;
    check("ch1_edge_pattern", pat, exp_pat);
    check("ps_count_edge", 128'(ps_cnt), 128'(1));
    check("ps_next_edge", 128'(period_start), 128'(1));

    // Saturation on channel 0: 10 presses reach PERIOD, 2 more stay there.
    for (int p = 0; p < 10; p++) press(0, 1'b1, 1'b0, 2);
    check("ch0_d_50", 128'(d[7:0]), 128'(50));
    for (int p = 0; p < 2; p++) press(0, 1'b1, 1'b0, 2);
    check("ch0_d_sat_hi", 128'(d[7:0]), 128'(50));
    wait_ps();
    measure(50, -1, -1, -1, 0);
    check("ch0_const_high", 128'(hi_cnt[0]), 128'(50));
    for (int p = 0; p < 11; p++) press(0, 1'b0, 1'b1, 2);
    check("ch0_d_sat_lo", 128'(d[7:0]), 128'(0));
    wait_ps();
    measure(50, -1, -1, -1, 0);
    check("ch0_const_low", 128'(hi_cnt[0]), 128'(0));

    // A long hold on channel 3 counts as a single press.
    press(3, 1'b1, 1'b0, 20);
    check("ch3_hold_once", 128'(d[31:24]), 128'(5));

    // Channel 2: one press, then simultaneous inc+dec leaves it unchanged.
    press(2, 1'b1, 1'b0, 3);
    check("ch2_d_5", 128'(d[23:16]), 128'(5));
    press(2, 1'b1, 1'b1, 3);
    check("ch2_inc_dec_same", 128'(d[23:16]), 128'(5));

    // A press mid-period only affects the next period.
    wait_ps();
    measure(50, 2, 30, -1, 2);
    check("ch2_d_10", 128'(d[23:16]), 128'(10));
    check("ch2_cur_period", 128'(hi_cnt[2]), 128'(5));
    measure(50, -1, -1, -1, 2);
    check("ch2_next_period", 128'(hi_cnt[2]), 128'(10));

    // Center mode with duty 20 on channel 1, switched mid-period.
    press(1, 1'b1, 1'b0, 3);
    check("ch1_d_20", 128'(d[15:8]), 128'(20));
    wait_ps();
    measure(50, -1, -1, 20, 1);
    check("ch1_edge_before_switch", 128'(hi_cnt[1]), 128'(20));
    check("edge_period_not_cut", 128'(period_start), 128'(1));
    measure(98, -1, -1, -1, 1);
    check("center_ch1_high", 128'(hi_cnt[1]), 128'(40));
    check("center_ch2_high", 128'(hi_cnt[2]), 128'(20));
    check("center_ch3_high", 128'(hi_cnt[3]), 128'(10));
    check("center_ch0_high", 128'(hi_cnt[0]), 128'(0));
    check("center_ps_count", 128'(ps_cnt), 128'(1));
    check("center_period_98", 128'(period_start), 128'(1));
    exp_pat = '0;
    for (int k = 0; k < 20; k++) exp_pat[k] = 1'b1;
    for (int k = 78; k < 98; k++) exp_pat[k] = 1'b1;
    check("center_ch1_pattern", pat, exp_pat);

    // Mid-period reset with duty 35 on channel 3.
    for (int p = 0; p < 6; p++) press(3, 1'b1, 1'b0, 2);
    check("ch3_d_35", 128'(d[31:24]), 128'(35));
    wait_ps();
    repeat (25) step();
    check("ch3_high_at_25", 128'(pwm_out[3]), 128'(1));
    reset = 1'b1;
    step();
    check("midrst_pwm_out", 128'(pwm_out), 128'(0));
    check("midrst_d", 128'(d), 128'(0));
    check("midrst_period_start", 128'(period_start), 128'(0));
    reset  = 1'b0;
    center = 1'b0;
    step();
    check("midrst_ps_release", 128'(period_start), 128'(1));
    check("midrst_pwm_after", 128'(pwm_out), 128'(0));
    measure(50, -1, -1, -1, 3);
    check("post_rst_ps_count", 128'(ps_cnt), 128'(1));
    check("post_rst_edge_period", 128'(period_start), 128'(1));
    check("post_rst_ch3_low", 128'(hi_cnt[3]), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
